// File: rtl/mem_op_intake_if.sv
// Ring, resend, mem-op, write-data and message queue signals of the memory op intake block.
// The slave modport is the intake's view; master is the surrounding environment.
interface mem_op_intake_if;
    logic         inValid;
    logic [3:0]   inDest;
    logic [31:0]  inData;
    logic         inReady;
    logic         resendQempty;
    logic         rdResend;
    logic [39:0]  resendIn;
    logic         memOpQfull;
    logic         wrMemOp;
    logic [3:0]   memOpDestOut;
    logic [31:0]  memOpDataOut;
    logic         writeDataQfull;
    logic         wrWriteData;
    logic [127:0] writeDataOut;
    logic         msgFull;
    logic         wrMsg;
    logic [39:0]  msgOut;

    modport slave (
        input  inValid, inDest, inData, resendQempty, resendIn,
               memOpQfull, writeDataQfull, msgFull,
        output inReady, rdResend, wrMemOp, memOpDestOut, memOpDataOut,
               wrWriteData, writeDataOut, wrMsg, msgOut
    );

    modport master (
        output inValid, inDest, inData, resendQempty, resendIn,
               memOpQfull, writeDataQfull, msgFull,
        input  inReady, rdResend, wrMemOp, memOpDestOut, memOpDataOut,
               wrWriteData, writeDataOut, wrMsg, msgOut
    );
endinterface

// File: rtl/mem_op_intake.sv
// Memory op intake: arbitrates resend entries against ring words, forwards read headers
// immediately and assembles four-word flush lines before pushing header and line together.
module mem_op_intake (
    input  logic        clock,
    input  logic        reset,
    mem_op_intake_if.slave bus,
    output logic [15:0] opCount,
    output logic [7:0]  dropCount
);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    state_t       state;
    state_t       state_next;
    logic [1:0]   word_cnt;
    logic [3:0]   hdr_dest;
    logic [31:0]  hdr_data;
    logic [127:0] line;
    logic         latch_hdr;
    logic         store_word;
    logic         drop_inc;
    logic         resend_taken;
    logic [3:0]   resend_type;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign resend_type = bus.resendIn[35:32];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next       = state;
        bus.inReady      = 1'b0;
        bus.rdResend     = 1'b0;
        bus.wrMemOp      = 1'b0;
        bus.memOpDestOut = 4'd0;
        bus.memOpDataOut = 32'd0;
        bus.wrWriteData  = 1'b0;
        bus.writeDataOut = 128'd0;
        bus.wrMsg        = 1'b0;
        bus.msgOut       = 40'd0;
        latch_hdr        = 1'b0;
        store_word       = 1'b0;
        drop_inc         = 1'b0;
        resend_taken     = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    // A resend head blocked by its own full flag yields the cycle to the ring.
                    if (!bus.resendQempty) begin
                        if (resend_type == 4'b0010) begin
                            if (!bus.memOpQfull) begin
                                bus.rdResend     = 1'b1;
                                bus.wrMemOp      = 1'b1;
                                bus.memOpDestOut = bus.resendIn[39:36];
                                bus.memOpDataOut = bus.resendIn[31:0];
                                resend_taken     = 1'b1;
                            end
                        end else if (resend_type == 4'b0110) begin
                            if (!bus.msgFull) begin
                                bus.rdResend = 1'b1;
                                bus.wrMsg    = 1'b1;
                                bus.msgOut   = bus.resendIn;
                                resend_taken = 1'b1;
                            end
                        end else begin
                            bus.rdResend = 1'b1;
                            drop_inc     = 1'b1;
                            resend_taken = 1'b1;
                        end
                    end
                    if (!resend_taken) begin
                        if (bus.inData[28] || (bus.inDest == 4'd0)) begin
                            bus.inReady = !bus.memOpQfull;
                            if (bus.inValid && !bus.memOpQfull) begin
                                bus.wrMemOp      = 1'b1;
                                bus.memOpDestOut = bus.inDest;
                                bus.memOpDataOut = bus.inData;
                            end
                        end else begin
                            bus.inReady = 1'b1;
                            if (bus.inValid) begin
                                latch_hdr  = 1'b1;
                                state_next = COLLECT;
                            end
                        end
                    end
                end
                COLLECT: begin
                    bus.inReady = 1'b1;
                    if (bus.inValid) begin
                        store_word = 1'b1;
                        if (word_cnt == 2'd3) state_next = COMMIT;
                    end
                end
                COMMIT: begin
                    // Header and line leave together or not at all.
                    if (!bus.memOpQfull && !bus.writeDataQfull) begin
                        bus.wrMemOp      = 1'b1;
                        bus.memOpDestOut = hdr_dest;
                        bus.memOpDataOut = hdr_data;
                        bus.wrWriteData  = 1'b1;
                        bus.writeDataOut = line;
                        state_next       = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_cnt  <= 2'd0;
            hdr_dest  <= 4'd0;
            hdr_data  <= 32'd0;
            line      <= 128'd0;
            opCount   <= 16'd0;
            dropCount <= 8'd0;
        end else begin
            if (latch_hdr) begin
                hdr_dest <= bus.inDest;
                hdr_data <= bus.inData;
                word_cnt <= 2'd0;
            end
            if (store_word) begin
                line[{word_cnt, 5'd0} +: 32] <= bus.inData;
                word_cnt                     <= word_cnt + 2'd1;
            end
            opCount <= opCount + {15'd0, bus.wrMemOp};
            if (drop_inc) dropCount <= sat_inc8(dropCount);
        end
    end

endmodule

// File: tb/tb_mem_op_intake.sv
// Directed bench for mem_op_intake: read forwarding, flush assembly and backpressure,
// resend arbitration and drop saturation, and reset in the middle of a flush.
module tb_mem_op_intake;

    logic        clock;
    logic        reset;
    logic [15:0] opCount;
    logic [7:0]  dropCount;
    int          n_cmp;
    int          n_bad;

    mem_op_intake_if bus ();

    mem_op_intake dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .opCount   (opCount),
        .dropCount (dropCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_ring(input logic v, input logic [3:0] d, input logic [31:0] w);
        bus.inValid = v;
        bus.inDest  = d;
        bus.inData  = w;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.resendQempty   = 1'b1;
        bus.resendIn       = 40'd0;
        bus.memOpQfull     = 1'b0;
        bus.writeDataQfull = 1'b0;
        bus.msgFull        = 1'b0;
        drive_ring(1'b1, 4'd3, 32'h1000_0040);
        #2;
        check_val("rst_inReady", bus.inReady, 0);
        check_val("rst_wrMemOp", bus.wrMemOp, 0);
        tick();
        tick();
        check_val("rst_opCount", opCount, 0);
        check_val("rst_dropCount", dropCount, 0);

        // ring read header, zero latency
        reset = 1'b0;
        #1;
        check_val("rd_inReady", bus.inReady, 1);
        check_val("rd_wrMemOp", bus.wrMemOp, 1);
        check_val("rd_dest", bus.memOpDestOut, 3);
        check_val("rd_data", bus.memOpDataOut, 32'h1000_0040);
        tick();
        drive_ring(1'b0, 4'd0, 32'd0);
        check_val("rd_opCount", opCount, 1);

        // flush header plus four words
        drive_ring(1'b1, 4'd2, 32'h0000_0080);
        #1;
        check_val("fl_hdr_ready", bus.inReady, 1);
        check_val("fl_hdr_nopush", bus.wrMemOp, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_ring(1'b1, 4'd2, 32'h11 * (i + 1));
            #1;
            check_val("fl_word_ready", bus.inReady, 1);
            check_val("fl_word_nopush", bus.wrMemOp | bus.wrWriteData, 0);
            tick();
        end
        drive_ring(1'b0, 4'd0, 32'd0);
        #1;
        check_val("fl_wrMemOp", bus.wrMemOp, 1);
        check_val("fl_wrWriteData", bus.wrWriteData, 1);
        check_val("fl_dest", bus.memOpDestOut, 2);
        check_val("fl_hdr", bus.memOpDataOut, 32'h0000_0080);
        check_val("fl_line", bus.writeDataOut, 128'h00000044_00000033_00000022_00000011);
        tick();
        check_val("fl_opCount", opCount, 2);
        check_val("fl_idle_nopush", bus.wrMemOp, 0);

        // flush held in COMMIT by a full write-data queue
        bus.writeDataQfull = 1'b1;
        drive_ring(1'b1, 4'd4, 32'h0000_0100);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_ring(1'b1, 4'd4, i + 1);
            tick();
        end
        drive_ring(1'b1, 4'd3, 32'h1000_0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("hold_inReady", bus.inReady, 0);
            check_val("hold_nopush", bus.wrMemOp | bus.wrWriteData, 0);
            tick();
        end
        drive_ring(1'b0, 4'd0, 32'd0);
        bus.writeDataQfull = 1'b0;
        #1;
        check_val("hold_release", {bus.wrMemOp, bus.wrWriteData}, 2'b11);
        check_val("hold_line", bus.writeDataOut, 128'h00000004_00000003_00000002_00000001);
        check_val("hold_dest", bus.memOpDestOut, 4);
        tick();
        check_val("hold_opCount", opCount, 3);

        // resend read beats a ring read in the same cycle
        bus.resendQempty = 1'b0;
        bus.resendIn     = {4'd1, 4'b0010, 32'hA000_0100};
        drive_ring(1'b1, 4'd3, 32'h1000_0040);
        #1;
        check_val("rs_rdResend", bus.rdResend, 1);
        check_val("rs_wrMemOp", bus.wrMemOp, 1);
        check_val("rs_dest", bus.memOpDestOut, 1);
        check_val("rs_data", bus.memOpDataOut, 32'hA000_0100);
        check_val("rs_inReady", bus.inReady, 0);
        tick();
        bus.resendQempty = 1'b1;
        #1;
        check_val("rs_ring_ready", bus.inReady, 1);
        check_val("rs_ring_dest", bus.memOpDestOut, 3);
        check_val("rs_ring_data", bus.memOpDataOut, 32'h1000_0040);
        tick();
        drive_ring(1'b0, 4'd0, 32'd0);
        check_val("rs_opCount", opCount, 5);

        // message resend blocked, then released
        bus.resendQempty = 1'b0;
        bus.resendIn     = {4'd5, 4'b0110, 32'hDEAD_BEEF};
        bus.msgFull      = 1'b1;
        #1;
        check_val("msg_blocked", {bus.rdResend, bus.wrMsg}, 2'b00);
        tick();
        bus.msgFull = 1'b0;
        #1;
        check_val("msg_go", {bus.rdResend, bus.wrMsg, bus.wrMemOp}, 3'b110);
        check_val("msg_out", bus.msgOut, {4'd5, 4'b0110, 32'hDEAD_BEEF});
        tick();

        // discarded entries saturate the drop counter
        bus.resendIn = {4'd2, 4'b1111, 32'h1234_5678};
        #1;
        check_val("drop_pop", {bus.rdResend, bus.wrMsg, bus.wrMemOp}, 3'b100);
        tick();
        check_val("drop_one", dropCount, 1);
        repeat (299) tick();
        check_val("drop_sat", dropCount, 8'hFF);
        check_val("drop_opCount", opCount, 5);

        // blocked resend read yields to a ring flush header
        bus.resendIn   = {4'd1, 4'b0010, 32'hA000_0200};
        bus.memOpQfull = 1'b1;
        drive_ring(1'b1, 4'd2, 32'h0000_0000);
        #1;
        check_val("blk_rdResend", bus.rdResend, 0);
        check_val("blk_inReady", bus.inReady, 1);
        tick();
        bus.memOpQfull = 1'b0;
        drive_ring(1'b1, 4'd2, 32'hAAAA_0001);
        #1;
        check_val("col_no_pop", bus.rdResend, 0);
        tick();
        drive_ring(1'b1, 4'd2, 32'hAAAA_0002);
        tick();

        // reset in the middle of a flush
        reset = 1'b1;
        drive_ring(1'b0, 4'd0, 32'd0);
        bus.resendQempty = 1'b1;
        #1;
        check_val("mid_rst_inReady", bus.inReady, 0);
        tick();
        reset = 1'b0;
        check_val("mid_rst_opCount", opCount, 0);
        check_val("mid_rst_dropCount", dropCount, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("mid_rst_nopush", bus.wrMemOp | bus.wrWriteData, 0);
            tick();
        end
        drive_ring(1'b1, 4'd7, 32'h1000_0001);
        #1;
        check_val("post_rst_push", bus.wrMemOp, 1);
        check_val("post_rst_dest", bus.memOpDestOut, 7);
        tick();
        drive_ring(1'b0, 4'd0, 32'd0);
        check_val("post_rst_opCount", opCount, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_op_intake.md
MEM_OP_INTAKE -- requirements
Module: mem_op_intake

Interface
REQ-001 clock  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high; clock clock.
REQ-003 inValid  in  1  ring word valid.
REQ-004 inDest  in  4  ring word source core; 0 = display controller.
REQ-005 inData  in  32  ring word; header or flush payload word.
REQ-006 inReady  out  1  ring word consumed this cycle when high with inValid.
REQ-007 resendQempty  in  1  resend queue empty.
REQ-008 rdResend  out  1  pop resend queue.
REQ-009 resendIn  in  40  resend entry {dest[39:36], type[35:32], data[31:0]}.
REQ-010 memOpQfull  in  1  mem op queue full.
REQ-011 wrMemOp  out  1  push mem op queue.
REQ-012 memOpDestOut  out  4  mem op destination.
REQ-013 memOpDataOut  out  32  mem op data.
REQ-014 writeDataQfull  in  1  write data queue full.
REQ-015 wrWriteData  out  1  push write data queue.
REQ-016 writeDataOut  out  128  assembled flush line.
REQ-017 msgFull  in  1  outbound message queue full.
REQ-018 wrMsg  out  1  push outbound message.
REQ-019 msgOut  out  40  outbound message, equals resendIn.
REQ-020 opCount  out  16  count of wrMemOp pulses, wraps at 16'hFFFF.
REQ-021 dropCount  out  8  count of discarded resend entries, saturates at 8'hFF.

Function
REQ-022 States IDLE, COLLECT, COMMIT; 2-bit wordCnt; 32-bit header register; 128-bit line register.
REQ-023 All strobes are combinational single-cycle pulses from current state and inputs; each strobe is low whenever its guarding full/empty condition blocks it.
REQ-024 IDLE, resend has priority: ~resendQempty and type 4'b0010 and ~memOpQfull -> rdResend=1, wrMemOp=1, memOpDestOut=resendIn[39:36], memOpDataOut=resendIn[31:0], inReady=0.
REQ-025 IDLE: ~resendQempty and type 4'b0110 and ~msgFull -> rdResend=1, wrMsg=1, msgOut=resendIn, inReady=0.
REQ-026 IDLE: ~resendQempty and any other type -> rdResend=1, dropCount increments (saturating), inReady=0.
REQ-027 IDLE: resend head present but blocked by its own full flag -> no pop; ring input is serviced that cycle per REQ-028/029.
REQ-028 IDLE, ring read header (inData[28]=1, or inDest=0): inReady=~memOpQfull; on inValid&inReady -> wrMemOp=1 with inDest/inData, same cycle (zero latency).
REQ-029 IDLE, ring flush header (inData[28]=0, inDest!=0): inReady=1; latch inDest/inData, wordCnt<=0, go COLLECT; no mem op push.
REQ-030 COLLECT: inReady=1; each accepted word written to line bits [32*wordCnt+31 : 32*wordCnt], wordCnt increments; accepting word with wordCnt=3 -> COMMIT.
REQ-031 COMMIT: inReady=0; when ~memOpQfull & ~writeDataQfull -> wrMemOp=1 (latched header), wrWriteData=1 (line) same cycle, go IDLE; otherwise hold.
REQ-032 wrMemOp and wrWriteData of a flush are never split across cycles.
REQ-033 Resend queue not popped in COLLECT or COMMIT.
REQ-034 opCount increments on every wrMemOp cycle from either source; no more than one increment per cycle.
REQ-035 Outputs not being driven by an active strobe are 0.

Reset
REQ-036 Reset: state IDLE, wordCnt 0, header 0, line 0, opCount 0, dropCount 0; all strobes 0 and inReady 0 during reset cycle.
REQ-037 Reset mid-COLLECT or mid-COMMIT discards the partial flush; no push follows reset.

Verification
REQ-038 Ring read header dest 3, data 32'h1000_0040, queues empty -> wrMemOp same cycle, dest 3, data 32'h1000_0040, opCount 1.
REQ-039 Flush header dest 2, data 32'h0000_0080, then words 11,22,33,44 -> one cycle later wrMemOp+wrWriteData, writeDataOut 128'h00000044_00000033_00000022_00000011.
REQ-040 Flush complete with writeDataQfull high 5 cycles -> COMMIT holds, inReady 0, single push on 6th cycle.
REQ-041 Resend {4'd1,4'b0010,32'hA000_0100} and ring read valid same cycle -> resend pushed, inReady 0; ring op pushed next cycle.
REQ-042 Resend type 4'b0110 with msgFull high -> no pop; msgFull low -> wrMsg, msgOut equals entry; 300 type-4'b1111 entries -> dropCount 8'hFF.
REQ-043 Reset asserted after 2 flush words -> IDLE, no pushes; next header handled normally.
